// File: rtl/maze_tile_map_pkg.sv
// Shared types and helpers for the maze tile-map renderer.
//   tile_t     : 2-bit tile code (FLOOR, WALL, PELLET, POWER)
//   maze_init  : start-layout tile for a given (row, col) of a rows x cols grid
//   is_pellet  : true for the pellet class (PELLET or POWER)
package maze_pkg;

  typedef enum logic [1:0] {
    FLOOR  = 2'd0,
    WALL   = 2'd1,
    PELLET = 2'd2,
    POWER  = 2'd3
  } tile_t;

  // Border is solid wall, one power pellet just inside each corner,
  // ordinary pellets on every other interior tile.
  function automatic tile_t maze_init(input int row, input int col,
                                      input int rows, input int cols);
    if (row == 0 || row == rows - 1 || col == 0 || col == cols - 1)
      return WALL;
    if ((row == 1 || row == rows - 2) && (col == 1 || col == cols - 2))
      return POWER;
    return PELLET;
  endfunction

  function automatic logic is_pellet(input tile_t t);
    return (t == PELLET) || (t == POWER);
  endfunction

endpackage

// File: rtl/maze_tile_map_if.sv
// Bus bundle for maze_tile_map: render pixel in/colour out, game-logic
// write port, collision query port, and status.
//   master : game logic / video timing side (drives coordinates and writes)
//   slave  : the tile-map block
interface maze_tile_map_if #(
  parameter int GRID_ROWS = 8,
  parameter int GRID_COLS = 8
);
  localparam int RW = $clog2(GRID_ROWS);
  localparam int CW = $clog2(GRID_COLS);
  localparam int PW = $clog2(GRID_ROWS * GRID_COLS + 1);

  logic [9:0]    p_row;
  logic [9:0]    p_col;
  logic [11:0]   color_data;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [1:0]    wr_tile;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [1:0]    rd_tile;
  logic          ready;
  logic [PW-1:0] pellets_left;

  modport master (
    output p_row, p_col, wr_en, wr_row, wr_col, wr_tile, rd_row, rd_col,
    input  color_data, rd_tile, ready, pellets_left
  );

  modport slave (
    input  p_row, p_col, wr_en, wr_row, wr_col, wr_tile, rd_row, rd_col,
    output color_data, rd_tile, ready, pellets_left
  );
endinterface

// File: rtl/maze_tile_map_pixel_decode.sv
// First render stage: splits a screen pixel into tile coordinates and
// intra-tile offsets, and flags pixels that fall beyond the grid.
//   clk, reset          : clock, synchronous active-high reset
//   p_row, p_col        : screen pixel
//   tile_row_p1/col_p1  : tile coordinates (low bits; valid when !outside_p1)
//   off_row_p1/col_p1   : pixel offset inside the tile
//   outside_p1          : pixel is right of or below the tile grid
module maze_pixel_decode #(
  parameter int GRID_ROWS = 8,
  parameter int GRID_COLS = 8,
  parameter int TILE_PX   = 20,
  localparam int RW = $clog2(GRID_ROWS),
  localparam int CW = $clog2(GRID_COLS),
  localparam int OW = $clog2(TILE_PX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    p_row,
  input  logic [9:0]    p_col,
  output logic [RW-1:0] tile_row_p1,
  output logic [CW-1:0] tile_col_p1,
  output logic [OW-1:0] off_row_p1,
  output logic [OW-1:0] off_col_p1,
  output logic          outside_p1
);

  // ---- stage 1: divide / remainder / range flag ----
  always_ff @(posedge clk) begin
    if (reset) begin
      tile_row_p1 <= '0;
      tile_col_p1 <= '0;
      off_row_p1  <= '0;
      off_col_p1  <= '0;
      outside_p1  <= 1'b0;
    end else begin
      tile_row_p1 <= RW'(p_row / 10'(TILE_PX));
      tile_col_p1 <= CW'(p_col / 10'(TILE_PX));
      off_row_p1  <= OW'(p_row % 10'(TILE_PX));
      off_col_p1  <= OW'(p_col % 10'(TILE_PX));
      outside_p1  <= ((p_row / 10'(TILE_PX)) >= 10'(GRID_ROWS)) ||
                     ((p_col / 10'(TILE_PX)) >= 10'(GRID_COLS));
    end
  end

endmodule

// File: rtl/maze_tile_map.sv
// Writable Pac-Man tile map with start-layout loader and pixel renderer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : maze_tile_map_if.slave
//     p_row/p_col -> color_data (2-cycle latency, one pixel per cycle)
//     wr_en/wr_row/wr_col/wr_tile : tile write, accepted only when ready
//     rd_row/rd_col -> rd_tile (1-cycle latency, out of range reads WALL)
//     ready        : start layout fully loaded
//     pellets_left : number of PELLET/POWER tiles
module maze_tile_map
  import maze_pkg::*;
#(
  parameter int          GRID_ROWS     = 8,
  parameter int          GRID_COLS     = 8,
  parameter int          TILE_PX       = 20,
  parameter logic [11:0] WALL_COLOR    = 12'h000,
  parameter logic [11:0] FLOOR_COLOR   = 12'h8AF,
  parameter logic [11:0] PELLET_COLOR  = 12'hFF0,
  parameter logic [11:0] OUTSIDE_COLOR = 12'h000
) (
  input logic           clk,
  input logic           reset,
  maze_tile_map_if.slave bus
);

  localparam int N  = GRID_ROWS * GRID_COLS;
  localparam int RW = $clog2(GRID_ROWS);
  localparam int CW = $clog2(GRID_COLS);
  localparam int PW = $clog2(N + 1);
  localparam int OW = $clog2(TILE_PX);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx;
  logic [PW-1:0] pellets;
  logic          ready;
  tile_t         tiles [N];
  tile_t         init_tile;

  logic          wr_in_range, wr_ok, cnt_inc, cnt_dec;
  logic [IW-1:0] wr_idx;
  tile_t         wr_new, wr_old;

  logic [RW-1:0] tile_row_p1;
  logic [CW-1:0] tile_col_p1;
  logic [OW-1:0] off_row_p1, off_col_p1;
  logic          outside_p1;
  logic [11:0]   color_p2;
  tile_t         rd_tile_q;

  // Counter step that holds at 0 and at N instead of wrapping.
  function automatic logic [PW-1:0] count_step(input logic [PW-1:0] cnt,
                                               input logic inc, input logic dec);
    if (inc && !dec && cnt != PW'(N)) return cnt + 1'b1;
    if (dec && !inc && cnt != '0)     return cnt - 1'b1;
    return cnt;
  endfunction

  function automatic tile_t tile_at(input logic [RW-1:0] r, input logic [CW-1:0] c);
    if (int'(r) >= GRID_ROWS || int'(c) >= GRID_COLS) return WALL;
    return tiles[IW'(int'(r) * GRID_COLS + int'(c))];
  endfunction

  function automatic logic [11:0] pixel_color(input logic outside, input tile_t t,
                                              input logic [OW-1:0] orow,
                                              input logic [OW-1:0] ocol);
    int r, c;
    r = int'(orow);
    c = int'(ocol);
    if (outside) return OUTSIDE_COLOR;
    case (t)
      WALL:    return WALL_COLOR;
      PELLET:  return (r >= TILE_PX/2 - 1 && r <= TILE_PX/2 &&
                       c >= TILE_PX/2 - 1 && c <= TILE_PX/2) ? PELLET_COLOR : FLOOR_COLOR;
      POWER:   return (r >= TILE_PX/2 - 4 && r <= TILE_PX/2 + 3 &&
                       c >= TILE_PX/2 - 4 && c <= TILE_PX/2 + 3) ? PELLET_COLOR : FLOOR_COLOR;
      default: return FLOOR_COLOR;
    endcase
  endfunction

  assign init_tile = maze_init(int'(idx) / GRID_COLS, int'(idx) % GRID_COLS,
                               GRID_ROWS, GRID_COLS);

  assign wr_in_range = (int'(bus.wr_row) < GRID_ROWS) && (int'(bus.wr_col) < GRID_COLS);
  assign wr_ok       = ready && bus.wr_en && wr_in_range;
  assign wr_idx      = wr_in_range ? IW'(int'(bus.wr_row) * GRID_COLS + int'(bus.wr_col)) : '0;
  assign wr_new      = tile_t'(bus.wr_tile);
  assign wr_old      = tiles[wr_idx];
  assign cnt_inc     = wr_ok && !is_pellet(wr_old) &&  is_pellet(wr_new);
  assign cnt_dec     = wr_ok &&  is_pellet(wr_old) && !is_pellet(wr_new);

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      S_INIT: if (idx == IW'(N - 1)) state_d = S_RUN;
      S_RUN: begin
        state_d = S_RUN;
        ready   = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      idx     <= '0;
      pellets <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        idx     <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        pellets <= count_step(pellets, is_pellet(init_tile), 1'b0);
      end else begin
        pellets <= count_step(pellets, cnt_inc, cnt_dec);
      end
    end
  end

  // Tile storage is plain data; the loader owns it until ready.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) tiles[idx]    <= init_tile;
    else if (wr_ok)        tiles[wr_idx] <= wr_new;
  end

  maze_pixel_decode #(
    .GRID_ROWS(GRID_ROWS),
    .GRID_COLS(GRID_COLS),
    .TILE_PX  (TILE_PX)
  ) u_decode (
    .clk        (clk),
    .reset      (reset),
    .p_row      (bus.p_row),
    .p_col      (bus.p_col),
    .tile_row_p1(tile_row_p1),
    .tile_col_p1(tile_col_p1),
    .off_row_p1 (off_row_p1),
    .off_col_p1 (off_col_p1),
    .outside_p1 (outside_p1)
  );

  // ---- stage 2: tile lookup and colour (reads see pre-write contents) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      color_p2  <= FLOOR_COLOR;
      rd_tile_q <= FLOOR;
    end else begin
      rd_tile_q <= tile_at(bus.rd_row, bus.rd_col);
      color_p2  <= ready ? pixel_color(outside_p1, tile_at(tile_row_p1, tile_col_p1),
                                       off_row_p1, off_col_p1)
                         : FLOOR_COLOR;
    end
  end

  assign bus.color_data   = color_p2;
  assign bus.rd_tile      = rd_tile_q;
  assign bus.ready        = ready;
  assign bus.pellets_left = pellets;

endmodule

// File: tb/tb_maze_tile_map.sv
module tb_maze_tile_map;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  maze_tile_map_if #(.GRID_ROWS(8), .GRID_COLS(8)) ifa ();
  maze_tile_map_if #(.GRID_ROWS(6), .GRID_COLS(6)) ifb ();

  maze_tile_map dut_a (.clk(clk), .reset(reset), .bus(ifa));
  maze_tile_map #(.GRID_ROWS(6), .GRID_COLS(6)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic rd_a(input int r, input int c, output logic [1:0] t);
    ifa.rd_row = 3'(r);
    ifa.rd_col = 3'(c);
    @(posedge clk); #1;
    t = ifa.rd_tile;
  endtask

  task automatic rd_b(input int r, input int c, output logic [1:0] t);
    ifb.rd_row = 3'(r);
    ifb.rd_col = 3'(c);
    @(posedge clk); #1;
    t = ifb.rd_tile;
  endtask

  task automatic wr_a(input int r, input int c, input logic [1:0] t);
    ifa.wr_en = 1'b1; ifa.wr_row = 3'(r); ifa.wr_col = 3'(c); ifa.wr_tile = t;
    @(posedge clk); #1;
    ifa.wr_en = 1'b0;
  endtask

  task automatic render_a(input int r, input int c, output logic [11:0] col);
    ifa.p_row = 10'(r);
    ifa.p_col = 10'(c);
    @(posedge clk);
    @(posedge clk); #1;
    col = ifa.color_data;
  endtask

  task automatic test_reset();
    int ka, kb;
    logic [1:0] t;
    ka = 0; kb = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ifa.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", ifa.ready); end
    checks++; if (ifa.pellets_left !== 7'd0) begin failures++; $display("FAIL reset_pellets got=%0d want=0", ifa.pellets_left); end
    checks++; if (ifa.rd_tile !== 2'd0) begin failures++; $display("FAIL reset_rd_tile got=%0d want=0", ifa.rd_tile); end
    checks++; if (ifa.color_data !== 12'h8AF) begin failures++; $display("FAIL reset_color got=%h want=8af", ifa.color_data); end
    reset = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      // write attempt landing on the 10th edge, while still loading
      if (k == 10) begin
        ifa.wr_en = 1'b1; ifa.wr_row = 3'd0; ifa.wr_col = 3'd5; ifa.wr_tile = 2'd2;
      end else ifa.wr_en = 1'b0;
      @(posedge clk); #1;
      if (ifa.ready && ka == 0) ka = k;
      if (ifb.ready && kb == 0) kb = k;
    end
    ifa.wr_en = 1'b0;
    checks++; if (ka != 64) begin failures++; $display("FAIL ready_edges_a got=%0d want=64", ka); end
    checks++; if (kb != 36) begin failures++; $display("FAIL ready_edges_b got=%0d want=36", kb); end
    checks++; if (ifa.pellets_left !== 7'd36) begin failures++; $display("FAIL init_pellets_a got=%0d want=36", ifa.pellets_left); end
    checks++; if (ifb.pellets_left !== 6'd16) begin failures++; $display("FAIL init_pellets_b got=%0d want=16", ifb.pellets_left); end
    rd_a(0, 5, t);
    checks++; if (t !== 2'd1) begin failures++; $display("FAIL init_write_ignored got=%0d want=1", t); end
  endtask

  task automatic test_read();
    logic [1:0] t;
    int rr [5] = '{0, 1, 3, 7, 1};
    int cc [5] = '{0, 1, 3, 7, 6};
    logic [1:0] ex [5] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 5; i++) begin
      rd_a(rr[i], cc[i], t);
      checks++;
      if (t !== ex[i]) begin failures++; $display("FAIL read_%0d_%0d got=%0d want=%0d", rr[i], cc[i], t, ex[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int pr [5] = '{0, 69, 61, 30, 200};
    int pc [5] = '{0, 69, 61, 30, 5};
    logic [11:0] ex [5] = '{12'h000, 12'hFF0, 12'h8AF, 12'hFF0, 12'h000};
    for (int j = 0; j <= 5; j++) begin
      if (j < 5) begin ifa.p_row = 10'(pr[j]); ifa.p_col = 10'(pc[j]); end
      @(posedge clk); #1;
      if (j >= 1) begin
        checks++;
        if (ifa.color_data !== ex[j-1]) begin
          failures++;
          $display("FAIL render_%0d_%0d got=%h want=%h", pr[j-1], pc[j-1], ifa.color_data, ex[j-1]);
        end
      end
    end
  endtask

  task automatic test_pellet_eat();
    logic [11:0] col;
    wr_a(3, 3, 2'd0);
    checks++; if (ifa.pellets_left !== 7'd35) begin failures++; $display("FAIL eat_count got=%0d want=35", ifa.pellets_left); end
    render_a(69, 69, col);
    checks++; if (col !== 12'h8AF) begin failures++; $display("FAIL eat_render got=%h want=8af", col); end
    wr_a(3, 3, 2'd0);
    checks++; if (ifa.pellets_left !== 7'd35) begin failures++; $display("FAIL rewrite_floor got=%0d want=35", ifa.pellets_left); end
    wr_a(3, 3, 2'd2);
    checks++; if (ifa.pellets_left !== 7'd36) begin failures++; $display("FAIL restore_pellet got=%0d want=36", ifa.pellets_left); end
    wr_a(1, 1, 2'd1);
    checks++; if (ifa.pellets_left !== 7'd35) begin failures++; $display("FAIL power_to_wall got=%0d want=35", ifa.pellets_left); end
    wr_a(1, 1, 2'd3);
  endtask

  task automatic test_same_cycle();
    logic [1:0] t;
    ifa.wr_en = 1'b1; ifa.wr_row = 3'd2; ifa.wr_col = 3'd2; ifa.wr_tile = 2'd0;
    ifa.rd_row = 3'd2; ifa.rd_col = 3'd2;
    @(posedge clk); #1;
    ifa.wr_en = 1'b0;
    checks++; if (ifa.rd_tile !== 2'd2) begin failures++; $display("FAIL same_cycle_old got=%0d want=2", ifa.rd_tile); end
    rd_a(2, 2, t);
    checks++; if (t !== 2'd0) begin failures++; $display("FAIL same_cycle_new got=%0d want=0", t); end
    checks++; if (ifa.pellets_left !== 7'd35) begin failures++; $display("FAIL same_cycle_count got=%0d want=35", ifa.pellets_left); end
    wr_a(2, 2, 2'd2);
  endtask

  task automatic test_out_of_range();
    logic [1:0] t;
    // column 6 of a 6-wide grid would alias tile (3,0) if not range-checked
    ifb.wr_en = 1'b1; ifb.wr_row = 3'd2; ifb.wr_col = 3'd6; ifb.wr_tile = 2'd2;
    @(posedge clk); #1;
    ifb.wr_row = 3'd6; ifb.wr_col = 3'd0;
    @(posedge clk); #1;
    ifb.wr_en = 1'b0;
    checks++; if (ifb.pellets_left !== 6'd16) begin failures++; $display("FAIL oor_count got=%0d want=16", ifb.pellets_left); end
    rd_b(3, 0, t);
    checks++; if (t !== 2'd1) begin failures++; $display("FAIL oor_alias got=%0d want=1", t); end
    rd_b(7, 0, t);
    checks++; if (t !== 2'd1) begin failures++; $display("FAIL oor_read got=%0d want=1", t); end
    rd_b(2, 2, t);
    checks++; if (t !== 2'd2) begin failures++; $display("FAIL b_read_2_2 got=%0d want=2", t); end
  endtask

  task automatic test_reset_mid_init();
    int ka;
    ka = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (ifa.ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%0b want=0", ifa.ready); end
    checks++; if (ifa.pellets_left !== 7'd0) begin failures++; $display("FAIL mid_reset_pellets got=%0d want=0", ifa.pellets_left); end
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (ifa.ready && ka == 0) ka = k;
    end
    checks++; if (ka != 64) begin failures++; $display("FAIL mid_reset_edges got=%0d want=64", ka); end
    checks++; if (ifa.pellets_left !== 7'd36) begin failures++; $display("FAIL mid_reset_count got=%0d want=36", ifa.pellets_left); end
  endtask

  initial begin
    reset = 1'b1;
    ifa.p_row = '0; ifa.p_col = '0; ifa.wr_en = 1'b0; ifa.wr_row = '0; ifa.wr_col = '0;
    ifa.wr_tile = '0; ifa.rd_row = '0; ifa.rd_col = '0;
    ifb.p_row = '0; ifb.p_col = '0; ifb.wr_en = 1'b0; ifb.wr_row = '0; ifb.wr_col = '0;
    ifb.wr_tile = '0; ifb.rd_row = '0; ifb.rd_col = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_read();
    test_back_to_back();
    test_pellet_eat();
    test_same_cycle();
    test_out_of_range();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
